// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_e;

  localparam int LINES_DEF = 16;
  localparam int WPL_DEF   = 4;
  localparam int OFFSET_W  = $clog2(WPL_DEF);
  localparam int INDEX_W   = $clog2(LINES_DEF);
  localparam int TAG_W     = 30 - OFFSET_W - INDEX_W;

  // Helpers return right-justified fields; callers slice to their own widths.
  function automatic logic [31:0] addr_offset(logic [31:0] a, int ow);
    return (a >> 2) & ((32'd1 << ow) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_index(logic [31:0] a, int ow, int iw);
    return (a >> (2 + ow)) & ((32'd1 << iw) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(logic [31:0] a, int ow, int iw);
    return a >> (2 + ow + iw);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid bits, tag RAM and data RAM: combinational read, synchronous writes.
module dcache_array #(
  parameter int LINES = 16,
  parameter int WPL   = 4,
  parameter int TAG_W = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(LINES)-1:0] idx,
  input  logic [$clog2(WPL)-1:0]   rd_off,
  input  logic [$clog2(WPL)-1:0]   wr_off,
  input  logic                     we,
  input  logic [31:0]              wr_data,
  input  logic                     inval,
  input  logic                     set,
  input  logic [TAG_W-1:0]         set_tag,
  output logic                     rd_valid,
  output logic [TAG_W-1:0]         rd_tag,
  output logic [31:0]              rd_word
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][WPL];

  // Reset wins over a same-edge line completion so an interrupted fill stays invalid.
  always_ff @(posedge clk) begin
    if (rst)        valid_q <= '0;
    else if (inval) valid_q[idx] <= 1'b0;
    else if (set)   valid_q[idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (set) tag_q[idx] <= set_tag;
    if (we)  data_q[idx][wr_off] <= wr_data;
  end

  assign rd_valid = valid_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_word  = data_q[idx][rd_off];

endmodule

// File: rtl/dcache_mem_stage.sv
// MEM-stage data cache: zero-latency read hits, line fill on read miss, write-through stores.
module dcache_mem_stage
  import dcache_pkg::*;
#(
  parameter int LINES          = LINES_DEF,
  parameter int WORDS_PER_LINE = WPL_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] readData,
  output logic        hit,
  output logic        stall,
  output logic [31:0] memAddr,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memWData,
  input  logic [31:0] memRData,
  input  logic        memAck
);

  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - OW - IW;
  localparam logic [OW-1:0] LAST = OW'(WORDS_PER_LINE - 1);

  state_e state_q, state_d;
  logic [OW-1:0] cnt_q, cnt_d;

  logic [31:0] off_full, idx_full, tag_full;
  logic [OW-1:0] off, wr_off;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag, rd_tag;
  logic [31:0] rd_word, wr_data;
  logic rd_valid, access, lookup_hit, arr_we, inval, line_set;
  logic unused_bits;

  assign off_full = addr_offset(address, OW);
  assign idx_full = addr_index(address, OW, IW);
  assign tag_full = addr_tag(address, OW, IW);
  assign off = off_full[OW-1:0];
  assign idx = idx_full[IW-1:0];
  assign tag = tag_full[TW-1:0];
  assign unused_bits = ^{off_full[31:OW], idx_full[31:IW], tag_full[31:TW]};

  assign access     = MemRead | MemWrite;
  assign lookup_hit = access && rd_valid && (rd_tag == tag);
  assign hit        = lookup_hit;
  assign readData   = access ? rd_word : 32'd0;

  dcache_array #(.LINES(LINES), .WPL(WORDS_PER_LINE), .TAG_W(TW)) u_array (
    .clk      (clk),
    .rst      (rst),
    .idx      (idx),
    .rd_off   (off),
    .wr_off   (wr_off),
    .we       (arr_we),
    .wr_data  (wr_data),
    .inval    (inval),
    .set      (line_set),
    .set_tag  (tag),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_word  (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (MemWrite) state_d = WRITE;
        else if (MemRead && !lookup_hit) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      FILL: begin
        if (memAck) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = IDLE;
        end
      end
      WRITE:   if (memAck) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall    = 1'b0;
    memReq   = 1'b0;
    memWe    = 1'b0;
    memAddr  = 32'd0;
    memWData = 32'd0;
    arr_we   = 1'b0;
    wr_off   = off;
    wr_data  = writeData;
    inval    = 1'b0;
    line_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MemWrite) begin
          stall  = 1'b1;
          arr_we = lookup_hit;
        end else if (MemRead && !lookup_hit) begin
          // Drop the victim up front so a half-overwritten line never looks valid.
          stall = 1'b1;
          inval = 1'b1;
        end
      end
      FILL: begin
        stall    = 1'b1;
        memReq   = 1'b1;
        memAddr  = {address[31:2+OW], cnt_q, 2'b00};
        wr_off   = cnt_q;
        wr_data  = memRData;
        arr_we   = memAck;
        line_set = memAck && (cnt_q == LAST);
      end
      WRITE: begin
        stall    = !memAck;
        memReq   = 1'b1;
        memWe    = 1'b1;
        memAddr  = {address[31:2], 2'b00};
        memWData = writeData;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_mem_stage.sv
// Bench for dcache_mem_stage: vector table through a scoreboard, plus reset-during-fill sequence.
module tb_dcache_mem_stage;

  logic        clk, rst;
  logic [31:0] address, writeData, readData, memAddr, memWData, memRData;
  logic        MemRead, MemWrite, hit, stall, memReq, memWe, memAck;

  dcache_mem_stage dut (
    .clk(clk), .rst(rst), .address(address), .writeData(writeData),
    .MemRead(MemRead), .MemWrite(MemWrite), .readData(readData), .hit(hit),
    .stall(stall), .memAddr(memAddr), .memReq(memReq), .memWe(memWe),
    .memWData(memWData), .memRData(memRData), .memAck(memAck)
  );

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic        f_hit, f_stall, d_hit, chk;
    logic [31:0] rdata;
    int          nrd, nwr;
  } vec_t;

  typedef struct {
    logic        hit, chk;
    logic [31:0] rdata;
    int          nrd, nwr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] addr_log[$];
  logic [31:0] mem_m [bit [31:0]];
  int n_rd = 0, n_wr = 0, n_chk = 0, n_pass = 0;
  bit mem_en = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] pat(logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [31:0] mem_rd(bit [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : pat(a);
  endfunction

  // Main memory: acks on alternate cycles while a request is up.
  initial begin
    memAck = 1'b0;
    memRData = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (memAck) begin
        memAck = 1'b0;
        memRData = 32'd0;
      end else if (memReq && mem_en) begin
        memAck = 1'b1;
        if (memWe) begin
          mem_m[memAddr] = memWData;
          n_wr++;
        end else begin
          memRData = mem_rd(memAddr);
          addr_log.push_back(memAddr);
          n_rd++;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] log_at(int k);
    return (k < addr_log.size()) ? addr_log[k] : 32'hFFFF_FFFF;
  endfunction

  task automatic run(input vec_t v);
    exp_t e;
    int rd0, wr0, cyc;
    MemRead = v.rd; MemWrite = v.wr; address = v.addr; writeData = v.wdata;
    e.hit = v.d_hit; e.chk = v.chk; e.rdata = v.rdata; e.nrd = v.nrd; e.nwr = v.nwr;
    sb.push_back(e);
    rd0 = n_rd; wr0 = n_wr;
    @(negedge clk);
    chk("first_hit", 32'(hit), 32'(v.f_hit));
    chk("first_stall", 32'(stall), 32'(v.f_stall));
    chk("first_req", 32'(memReq), 32'd0);
    cyc = 0;
    while (stall && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_stall", 32'(stall), 32'd0);
    e = sb.pop_front();
    chk("done_hit", 32'(hit), 32'(e.hit));
    if (e.chk) chk("done_data", readData, e.rdata);
    chk("n_rd", 32'(n_rd - rd0), 32'(e.nrd));
    chk("n_wr", 32'(n_wr - wr0), 32'(e.nwr));
    @(posedge clk);
    #1;
    chk("req_drop", 32'(memReq), 32'd0);
  endtask

  vec_t tv[16];

  initial begin
    int base, cyc;
    mem_m[32'h100] = 32'hA0; mem_m[32'h104] = 32'hA1;
    mem_m[32'h108] = 32'hA2; mem_m[32'h10C] = 32'hA3;
    //        rd wr addr          wdata           fh fs dh ck rdata           nrd nwr
    tv[0]  = '{1, 0, 32'h104, 32'h0,          0, 1, 1, 1, 32'hA1,         4, 0};
    tv[1]  = '{1, 0, 32'h10C, 32'h0,          1, 0, 1, 1, 32'hA3,         0, 0};
    tv[2]  = '{0, 1, 32'h108, 32'hDEAD_BEEF,  1, 1, 1, 1, 32'hDEAD_BEEF,  0, 1};
    tv[3]  = '{1, 0, 32'h108, 32'h0,          1, 0, 1, 1, 32'hDEAD_BEEF,  0, 0};
    tv[4]  = '{0, 1, 32'h200, 32'h1234_5678,  0, 1, 0, 0, 32'h0,          0, 1};
    tv[5]  = '{1, 0, 32'h104, 32'h0,          1, 0, 1, 1, 32'hA1,         0, 0};
    tv[6]  = '{1, 0, 32'h200, 32'h0,          0, 1, 1, 1, 32'h1234_5678,  4, 0};
    tv[7]  = '{1, 0, 32'h104, 32'h0,          0, 1, 1, 1, 32'hA1,         4, 0};
    tv[8]  = '{0, 0, 32'h104, 32'h0,          0, 0, 0, 1, 32'h0,          0, 0};
    tv[9]  = '{1, 1, 32'h10C, 32'h55,         1, 1, 1, 1, 32'h55,         0, 1};
    tv[10] = '{1, 0, 32'h10C, 32'h0,          1, 0, 1, 1, 32'h55,         0, 0};
    tv[11] = '{1, 0, 32'hF38, 32'h0,          0, 1, 1, 1, pat(32'hF38),   4, 0};
    tv[12] = '{1, 0, 32'hF30, 32'h0,          1, 0, 1, 1, pat(32'hF30),   0, 0};
    tv[13] = '{0, 1, 32'hF3C, 32'h77,         1, 1, 1, 1, 32'h77,         0, 1};
    tv[14] = '{1, 0, 32'hF3C, 32'h0,          1, 0, 1, 1, 32'h77,         0, 0};
    tv[15] = '{1, 0, 32'h108, 32'h0,          1, 0, 1, 1, 32'hDEAD_BEEF,  0, 0};

    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; address = 32'd0; writeData = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_memReq", 32'(memReq), 32'd0);
    chk("rst_memWe", 32'(memWe), 32'd0);
    chk("rst_memAddr", memAddr, 32'd0);
    chk("rst_memWData", memWData, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_readData", readData, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      run(tv[i]);
      if (i == 0)
        for (int k = 0; k < 4; k++) chk("fill_addr", log_at(k), 32'h100 + 32'(4 * k));
    end
    chk("wt_mem_108", mem_rd(32'h108), 32'hDEAD_BEEF);
    chk("wt_mem_10C", mem_rd(32'h10C), 32'h55);

    // Reset lands after the second fill ack; the line must be refilled from scratch.
    addr_log.delete();
    base = n_rd;
    MemRead = 1'b1; MemWrite = 1'b0; address = 32'hA54;
    cyc = 0;
    while ((n_rd - base) < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_acks", 32'(n_rd - base), 32'd2);
    @(posedge clk);
    #1 rst = 1'b1; mem_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", 32'(memReq), 32'd0);
    chk("mid_rst_hit", 32'(hit), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd1);
    addr_log.delete();
    base = n_rd;
    mem_en = 1'b1;
    cyc = 0;
    while (stall && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("refill_stall", 32'(stall), 32'd0);
    chk("refill_hit", 32'(hit), 32'd1);
    chk("refill_data", readData, pat(32'hA54));
    chk("refill_n_rd", 32'(n_rd - base), 32'd4);
    chk("refill_addr0", log_at(0), 32'hA50);
    chk("refill_addr3", log_at(3), 32'hA5C);
    @(posedge clk);
    #1 MemRead = 1'b0;
    @(negedge clk);
    chk("final_idle_req", 32'(memReq), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
